lsu: RTL and testbench

Load/store unit sitting directly upstream of the data memory `dmem`. Accepts one load or store per handshake from the CPU memory stage and drives `dmem`'s word port (`we`/`daddr`/`wdata`/`rdata`). Word stores write directly; byte and halfword stores use a read-modify-write sequence. Loads are returned byte-, half- or word-wide with sign or zero extension. Accesses that would run past the end of the 256-byte memory window are reported as faults.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_ext.sv | 20 ++
 rtl/lsu.sv | 106 ++++++++++
 tb/tb_lsu.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and helpers for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Access width in bytes; the illegal encoding reports zero.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_B:    bytes_of = 3'd1;
      SZ_H:    bytes_of = 3'd2;
      SZ_W:    bytes_of = 3'd4;
      default: bytes_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - picks the low byte/half/word of a read buffer and sign- or zero-extends it
module load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] rbuf,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  always_comb begin
    data = rbuf;
    case (size)
      SZ_B:    data = {{24{~uns & rbuf[7]}}, rbuf[7:0]};
      SZ_H:    data = {{16{~uns & rbuf[15]}}, rbuf[15:0]};
      default: data = rbuf;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit driving the dmem word port, with RMW for sub-word stores
module lsu
  import lsu_pkg::*;
#(
  parameter int WIN_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_daddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf;
  logic [31:0] ext_data;
  logic [31:0] merged;

  // One extra bit so an access ending exactly at the window top is not mistaken for wrap.
  logic [WIN_BITS:0] end_off;
  logic              fault;

  assign end_off = {1'b0, req_addr[WIN_BITS-1:0]} + (WIN_BITS+1)'(bytes_of(req_size));
  assign fault   = (req_size == 2'b11) || (end_off > {1'b1, {WIN_BITS{1'b0}}});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= fault;
            if (fault)
              state <= ST_RESP;
            else if (req_we && req_size == SZ_W)
              state <= ST_WR;
            else
              state <= ST_RD;
          end
        end
        ST_RD: begin
          rbuf  <= mem_rdata;
          state <= we_q ? ST_WR : ST_RESP;
        end
        ST_WR:   state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase
    end
  end

  load_ext u_load_ext (
    .rbuf (rbuf),
    .size (size_q),
    .uns  (uns_q),
    .data (ext_data)
  );

  always_comb begin
    case (size_q)
      SZ_W:    merged = wdata_q;
      SZ_H:    merged = {rbuf[31:16], wdata_q[15:0]};
      default: merged = {rbuf[31:8], wdata_q[7:0]};
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_rdata = ((state == ST_RESP) && !we_q && !err_q) ? ext_data : 32'd0;

  // Gating with rst lets a reset landing on the WR cycle cancel the write.
  assign mem_we    = (state == ST_WR) && rst;
  assign mem_daddr = (state == ST_RD || state == ST_WR) ? addr_q : 32'd0;
  assign mem_wdata = (state == ST_WR) ? merged : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu against a byte-array memory model
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_daddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu #(.WIN_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_daddr    (mem_daddr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // dmem stand-in: 256 bytes, little-endian word port, combinational read.
  logic [7:0] dmem [256] = '{default: 8'h00};
  logic [7:0] da;
  assign da = mem_daddr[7:0];
  assign mem_rdata = {dmem[da + 8'd3], dmem[da + 8'd2], dmem[da + 8'd1], dmem[da]};

  always @(posedge clk) begin
    if (mem_we) begin
      dmem[da]        <= mem_wdata[7:0];
      dmem[da + 8'd1] <= mem_wdata[15:8];
      dmem[da + 8'd2] <= mem_wdata[23:16];
      dmem[da + 8'd3] <= mem_wdata[31:24];
    end
  end

  // Reference memory contents as the spec's rules say they should evolve.
  logic [7:0] mem_m [256] = '{default: 8'h00};

  task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic err, output logic [31:0] rdata, output int lat);
    int n;
    int off;
    logic [63:0] v;
    off = int'(addr[7:0]);
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    err = (size == 2'd3) || (off + n > 256);
    rdata = 32'd0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(mem_m[off + i]) << (8 * i));
      if (!uns && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rdata = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < n; i++) mem_m[off + i] = wdata[8 * i +: 8];
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_garbage();
    logic [31:0] r;
    r = $urandom;
    req_we       = r[0];
    req_size     = r[2:1];
    req_unsigned = r[3];
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Issue one request and watch it to completion; garbage with valid high stands in while busy.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic err, output logic [31:0] rdata,
                        output int lat, output int wecnt, output int wecyc);
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    chk("no_resp_idle", 32'(resp_valid), 32'd0);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    drive_garbage();
    err = 1'b0; rdata = 32'd0; lat = -1; wecnt = 0; wecyc = -1;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) begin wecnt++; wecyc = c; end
      if (resp_valid) begin
        lat = c; err = resp_err; rdata = resp_rdata;
        req_valid = 1'b0;
        break;
      end
      @(negedge clk);
      drive_garbage();
    end
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                  logic [31:0] wdata, logic exp_err, logic [31:0] exp_rdata,
                                  int exp_lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endfunction

  task automatic check_resp(input string tag, input logic we, input logic err,
                            input logic [31:0] rdata, input int lat, input int wecnt,
                            input int wecyc, input logic exp_err, input logic [31:0] exp_rdata,
                            input int exp_lat);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_we_count"}, 32'(wecnt), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) chk({tag, "_we_cycle"}, 32'(wecyc), 32'(exp_lat - 1));
  endtask

  initial begin
    logic        m_err, d_err;
    logic [31:0] m_rdata, d_rdata;
    int          m_lat, d_lat, wecnt, wecyc;

    rst = 1'b0; req_valid = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_daddr", mem_daddr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // we, size, uns, addr, wdata, exp_err, exp_rdata, exp_lat
    add_vec(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 2);
    add_vec(0, 2'd2, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 2);
    add_vec(1, 2'd2, 0, 32'h20, 32'h11223344, 0, 32'h0, 2);
    add_vec(1, 2'd0, 0, 32'h21, 32'h777777AB, 0, 32'h0, 3);
    add_vec(0, 2'd2, 0, 32'h20, 32'h0, 0, 32'h1122AB44, 2);
    add_vec(1, 2'd0, 0, 32'h30, 32'hFFFFFF80, 0, 32'h0, 3);
    add_vec(0, 2'd0, 0, 32'h30, 32'h0, 0, 32'hFFFFFF80, 2);
    add_vec(0, 2'd0, 1, 32'h30, 32'h0, 0, 32'h00000080, 2);
    add_vec(1, 2'd1, 0, 32'h32, 32'h12348001, 0, 32'h0, 3);
    add_vec(0, 2'd1, 0, 32'h32, 32'h0, 0, 32'hFFFF8001, 2);
    add_vec(0, 2'd1, 1, 32'h32, 32'h0, 0, 32'h00008001, 2);
    add_vec(1, 2'd2, 0, 32'hFC, 32'h01020304, 0, 32'h0, 2);
    add_vec(1, 2'd2, 0, 32'hFD, 32'hCAFEF00D, 1, 32'h0, 1);
    add_vec(0, 2'd2, 0, 32'hFC, 32'h0, 0, 32'h01020304, 2);
    add_vec(0, 2'd1, 0, 32'hFF, 32'h0, 1, 32'h0, 1);
    add_vec(1, 2'd0, 0, 32'hFF, 32'h0000005A, 0, 32'h0, 3);
    add_vec(0, 2'd0, 1, 32'hFF, 32'h0, 0, 32'h0000005A, 2);
    add_vec(0, 2'd2, 0, 32'hFC, 32'h0, 0, 32'h5A020304, 2);
    add_vec(0, 2'd3, 0, 32'h00, 32'h0, 1, 32'h0, 1);
    add_vec(1, 2'd3, 0, 32'h40, 32'h0, 1, 32'h0, 1);
    add_vec(0, 2'd2, 0, 32'hABCD0010, 32'h0, 0, 32'hDEADBEEF, 2);

    foreach (vecs[i]) begin
      model_op(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
               m_err, m_rdata, m_lat);
      do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             d_err, d_rdata, d_lat, wecnt, wecyc);
      check_resp($sformatf("vec%0d", i), vecs[i].we, d_err, d_rdata, d_lat, wecnt, wecyc,
                 vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
    end

    // Reset landing on the WR cycle of a byte store must cancel it silently.
    begin
      int stray;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'h55;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstwr_we_before", 32'(mem_we), 32'd1);
      rst = 1'b0;
      #1;
      chk("rstwr_we_gated", 32'(mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      chk("rstwr_ready", 32'(req_ready), 32'd1);
      chk("rstwr_resp_valid", 32'(resp_valid), 32'd0);
      chk("rstwr_daddr", mem_daddr, 32'd0);
      stray = 0;
      repeat (4) begin
        @(negedge clk);
        if (resp_valid) stray++;
      end
      chk("rstwr_no_resp", 32'(stray), 32'd0);
      model_op(0, 2'd0, 1, 32'h40, 32'h0, m_err, m_rdata, m_lat);
      do_req(0, 2'd0, 1, 32'h40, 32'h0, d_err, d_rdata, d_lat, wecnt, wecyc);
      check_resp("rstwr_load", 0, d_err, d_rdata, d_lat, wecnt, wecyc, m_err, m_rdata, m_lat);
    end

    // Randomized traffic against the model, biased toward the window top.
    for (int k = 0; k < 80; k++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr, wdata, r;
      r = $urandom;
      we = r[0];
      uns = r[1];
      size = (r[6:4] == 3'd0) ? 2'd3 : 2'(r[9:8] % 2'd3);
      addr = $urandom;
      addr[7:0] = (r[3:2] == 2'd0) ? 8'(252 + 32'(r[11:10])) : {2'b00, r[17:12]};
      wdata = $urandom;
      model_op(we, size, uns, addr, wdata, m_err, m_rdata, m_lat);
      do_req(we, size, uns, addr, wdata, d_err, d_rdata, d_lat, wecnt, wecyc);
      check_resp($sformatf("rnd%0d", k), we, d_err, d_rdata, d_lat, wecnt, wecyc,
                 m_err, m_rdata, m_lat);
    end

    // Back-to-back with req_valid held high: accept exactly one cycle after each response.
    begin
      localparam int N = 10;
      logic        exp_err_q[$];
      logic [31:0] exp_rd_q[$];
      int acc, rsp, last_resp, cyc;
      logic [31:0] a;
      acc = 0; rsp = 0; last_resp = 0; cyc = 0;
      while (rsp < N && cyc < 200) begin
        @(negedge clk);
        cyc++;
        if (resp_valid) begin
          chk("b2b_err", 32'(resp_err), 32'(exp_err_q.pop_front()));
          chk("b2b_rdata", resp_rdata, exp_rd_q.pop_front());
          last_resp = cyc;
          rsp++;
        end
        if (req_ready) begin
          if (acc > 0) chk("b2b_accept_gap", 32'(cyc - last_resp), 32'd1);
          if (acc < N) begin
            a = {$urandom, 2'b00} & 32'h0000_003C;
            req_valid = 1'b1;
            req_we = acc[0];
            req_size = 2'(acc % 3);
            req_unsigned = acc[1];
            req_addr = a;
            req_wdata = $urandom;
            model_op(req_we, req_size, req_unsigned, req_addr, req_wdata, m_err, m_rdata, m_lat);
            exp_err_q.push_back(m_err);
            exp_rd_q.push_back(m_rdata);
            acc++;
          end else begin
            req_valid = 1'b0;
          end
        end else begin
          drive_garbage();
          req_valid = (acc < N);
        end
      end
      req_valid = 1'b0;
      chk("b2b_resp_count", 32'(rsp), 32'(N));
    end

    begin
      int diffs;
      diffs = 0;
      for (int i = 0; i < 256; i++) if (dmem[i] !== mem_m[i]) diffs++;
      chk("mem_final_diffs", 32'(diffs), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
